// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill engine: field widths,
// address slice positions and the refill FSM state encoding.
package icache_pkg;

    localparam int TAG_W      = 21;
    localparam int INDEX_W    = 4;
    localparam int OFFSET_W   = 5;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 32;
    localparam int CNT_W      = 6;

    localparam int TAG_LSB    = 11;
    localparam int INDEX_LSB  = 7;
    localparam int OFFSET_LSB = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_cache_refill.sv
// Instruction-cache miss refill: fetches a 32-word line with up to MAX_OUT reads
// in flight, writes it to line storage, then installs the tag. Optional critical-word-first
// ordering and forwarding is enabled by defining ICACHE_CRITICAL_WORD_FIRST_EN.
module instr_cache_refill
    import icache_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                miss_i,
    input  logic [31:0]         miss_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_req_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [WORD_W-1:0]   mem_rdata_i,
    output logic                wr_en_o,
    output logic [INDEX_W-1:0]  wr_index_o,
    output logic [OFFSET_W-1:0] wr_offset_o,
    output logic [WORD_W-1:0]   wr_data_o,
    output logic                tag_wr_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                fwd_valid_o,
    output logic [WORD_W-1:0]   fwd_data_o,
    output state_t              state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    // Handshakes: a request transfers on a cycle with mem_req_o && mem_ready_i, and
    // mem_req_o/mem_addr_o hold until then; mem_rvalid_i carries one in-order word per cycle.
    state_t                state_q, state_d;
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_W-1:0]    index_q;
    logic [OFFSET_W-1:0]   start_q, start_sel, req_off;
    logic [CNT_W-1:0]      req_cnt_q, rsp_cnt_q;
    logic                  accept_miss, req_fire, rsp_fire;
    logic                  wr_en_q;
    logic [INDEX_W-1:0]    wr_index_q;
    logic [OFFSET_W-1:0]   wr_offset_q;
    logic [WORD_W-1:0]     wr_data_q;
    logic                  unused_addr_bits;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign start_sel = miss_addr_i[OFFSET_LSB +: OFFSET_W];
`else
    assign start_sel = '0;
`endif
    assign unused_addr_bits = ^miss_addr_i[INDEX_LSB-1:0];

    always_comb begin
        state_d     = state_q;
        accept_miss = 1'b0;
        mem_req_o   = 1'b0;
        if (state_q == FILL) begin
            // Outstanding limiter: issued minus returned must stay below MAX_OUT.
            mem_req_o = (req_cnt_q < CNT_FULL) && ((req_cnt_q - rsp_cnt_q) < MAX_OUT_C);
        end
        req_fire = mem_req_o && mem_ready_i;
        rsp_fire = mem_rvalid_i && ((state_q == FILL) || (state_q == DRAIN)) &&
                   (rsp_cnt_q < CNT_FULL);
        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    accept_miss = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (rsp_fire && (rsp_cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                end else if (req_fire && (req_cnt_q == CNT_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_fire && (rsp_cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            start_q     <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_index_q  <= '0;
            wr_offset_q <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_miss) begin
                tag_q     <= miss_addr_i[TAG_LSB +: TAG_W];
                index_q   <= miss_addr_i[INDEX_LSB +: INDEX_W];
                start_q   <= start_sel;
                req_cnt_q <= '0;
                rsp_cnt_q <= '0;
            end else begin
                if (req_fire) req_cnt_q <= req_cnt_q + CNT_W'(1);
                if (rsp_fire) rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            end
            wr_en_q <= rsp_fire;
            if (rsp_fire) begin
                wr_index_q  <= index_q;
                wr_offset_q <= start_q + rsp_cnt_q[OFFSET_W-1:0];
                wr_data_q   <= mem_rdata_i;
            end
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic              fwd_valid_q;
    logic [WORD_W-1:0] fwd_data_q;

    // The first returned word is the one the stalled fetch is waiting for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= rsp_fire && (rsp_cnt_q == '0);
            if (rsp_fire && (rsp_cnt_q == '0)) fwd_data_q <= mem_rdata_i;
        end
    end
    assign fwd_valid_o = fwd_valid_q;
    assign fwd_data_o  = fwd_data_q;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = '0;
`endif

    assign req_off     = start_q + req_cnt_q[OFFSET_W-1:0];
    assign mem_addr_o  = {tag_q, index_q, req_off, 2'b00};
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign tag_wr_o    = (state_q == DONE);
    assign tag_o       = tag_q;
    assign wr_en_o     = wr_en_q;
    assign wr_index_o  = wr_index_q;
    assign wr_offset_o = wr_offset_q;
    assign wr_data_o   = wr_data_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Bench for instr_cache_refill: in-order memory models, a line-level refill model
// with expected queues, and directed scenarios on a MAX_OUT=4 and a MAX_OUT=1 instance.
module tb_instr_cache_refill;
    import icache_pkg::*;

    localparam int MAX_OUT_A = 4;
    localparam int MAX_OUT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Instance A signals
    logic        rst_n;
    logic        miss;
    logic [31:0] miss_addr;
    logic        busy, done, mem_req, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        wr_en, tag_wr, fwd_valid;
    logic [3:0]  wr_index;
    logic [4:0]  wr_offset;
    logic [31:0] wr_data, fwd_data;
    logic [20:0] tag;
    state_t      state_a;

    // Instance B signals
    logic        b_miss;
    logic [31:0] b_miss_addr;
    logic        b_busy, b_done, b_req, b_ready, b_rvalid;
    logic [31:0] b_addr, b_rdata;
    logic        b_wr_en, b_tag_wr, b_fwd_valid;
    logic [3:0]  b_wr_index;
    logic [4:0]  b_wr_offset;
    logic [31:0] b_wr_data, b_fwd_data;
    logic [20:0] b_tag;
    state_t      state_b;

    instr_cache_refill #(.MAX_OUT(MAX_OUT_A)) dut (
        .clk_i(clk), .rst_ni(rst_n), .miss_i(miss), .miss_addr_i(miss_addr),
        .busy_o(busy), .done_o(done), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wr_en_o(wr_en), .wr_index_o(wr_index), .wr_offset_o(wr_offset), .wr_data_o(wr_data),
        .tag_wr_o(tag_wr), .tag_o(tag), .fwd_valid_o(fwd_valid), .fwd_data_o(fwd_data),
        .state_o(state_a)
    );

    instr_cache_refill #(.MAX_OUT(MAX_OUT_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .miss_i(b_miss), .miss_addr_i(b_miss_addr),
        .busy_o(b_busy), .done_o(b_done), .mem_req_o(b_req), .mem_addr_o(b_addr),
        .mem_ready_i(b_ready), .mem_rvalid_i(b_rvalid), .mem_rdata_i(b_rdata),
        .wr_en_o(b_wr_en), .wr_index_o(b_wr_index), .wr_offset_o(b_wr_offset), .wr_data_o(b_wr_data),
        .tag_wr_o(b_tag_wr), .tag_o(b_tag), .fwd_valid_o(b_fwd_valid), .fwd_data_o(b_fwd_data),
        .state_o(state_b)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=nothing", name, act);
    endfunction

    // ---------------- memory model A: in-order, fixed latency ----------------
    int          lat        = 3;
    logic        rand_ready = 1'b0;
    int          stray_tok  = 0;
    int          stray_seen = 0;
    logic        stray_active = 1'b0;
    logic [31:0] mq[$];
    int          dq[$];

    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete(); dq.delete();
            end else begin
                if (mem_rvalid && !stray_active && mq.size() > 0) begin
                    void'(mq.pop_front()); void'(dq.pop_front());
                end
                if (mem_req && mem_ready) begin
                    mq.push_back(mem_addr); dq.push_back(cyc + lat);
                end
            end
            @(posedge clk); #1;
            stray_active = 1'b0;
            if (stray_tok != stray_seen) begin
                stray_seen = stray_tok;
                mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; stray_active = 1'b1;
            end else if (rst_n && mq.size() > 0 && dq[0] <= cyc) begin
                mem_rvalid = 1'b1; mem_rdata = mq[0];
            end else begin
                mem_rvalid = 1'b0; mem_rdata = '0;
            end
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- memory model B: in-order, 5-cycle latency ----------------
    logic [31:0] bq[$];
    int          bdq[$];

    initial begin
        b_ready = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bq.delete(); bdq.delete();
            end else begin
                if (b_rvalid && bq.size() > 0) begin
                    void'(bq.pop_front()); void'(bdq.pop_front());
                end
                if (b_req && b_ready) begin
                    bq.push_back(b_addr); bdq.push_back(cyc + 5);
                end
            end
            @(posedge clk); #1;
            if (rst_n && bq.size() > 0 && bdq[0] <= cyc) begin
                b_rvalid = 1'b1; b_rdata = bq[0];
            end else begin
                b_rvalid = 1'b0; b_rdata = '0;
            end
            b_ready = 1'b1;
        end
    end

    // ---------------- line-level refill model and scoreboard for A ----------------
    logic [31:0] exp_req_q[$];
    logic [40:0] exp_wr_q[$];
    logic [31:0] req_log[$];
    logic [40:0] wr_log[$];
    logic        model_busy = 1'b0;
    logic        first_wr_pending = 1'b0;
    logic [20:0] exp_tag = '0;
    logic [20:0] last_tag = '0;
    int          acc = 0, rsp = 0, done_cnt = 0, wr_total = 0, fwd_cnt = 0;
    logic [31:0] fwd_last = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        exp_done, exp_fwd;
    logic [31:0] exp_fwd_data;
    logic [40:0] cmp_e;

    // A refill fetches the whole line in wrap order from the start word; memory returns address as data.
    task automatic model_start(input logic [31:0] a);
        logic [4:0]  s, o;
        logic [31:0] ra;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        s = a[6:2];
`else
        s = 5'd0;
`endif
        exp_req_q.delete(); exp_wr_q.delete(); req_log.delete(); wr_log.delete();
        for (int i = 0; i < 32; i++) begin
            o  = s + 5'(i);
            ra = {a[31:7], o, 2'b00};
            exp_req_q.push_back(ra);
            exp_wr_q.push_back({a[10:7], o, ra});
        end
        exp_tag = a[31:11];
        first_wr_pending = 1'b1;
        acc = 0;
        rsp = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl_zero", 64'({busy, done, mem_req, wr_en, tag_wr, fwd_valid}), 64'd0);
            chk("reset_addr_data_zero", {mem_addr, wr_data}, 64'd0);
            model_busy = 1'b0;
            exp_req_q.delete(); exp_wr_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(model_busy));
            if (mem_req) chk("outstanding_limit", 64'((acc - rsp) < MAX_OUT_A), 64'd1);
            if (prev_stall) chk("req_held", 64'({mem_req, mem_addr}), 64'({1'b1, prev_addr}));
            if (mem_req && mem_ready) begin
                if (exp_req_q.size() == 0) fail_now("unexpected_request", 64'(mem_addr));
                else chk("req_addr", 64'(mem_addr), 64'(exp_req_q.pop_front()));
                req_log.push_back(mem_addr);
                acc++;
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            if (mem_rvalid && model_busy) rsp++;
            exp_done = 1'b0;
            exp_fwd  = 1'b0;
            exp_fwd_data = '0;
            if (wr_en) begin
                wr_total++;
                wr_log.push_back({wr_index, wr_offset, wr_data});
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_write", 64'({wr_index, wr_offset, wr_data}));
                end else begin
                    cmp_e = exp_wr_q.pop_front();
                    chk("wr_word", 64'({wr_index, wr_offset, wr_data}), 64'(cmp_e));
                    exp_done = (exp_wr_q.size() == 0);
                    exp_fwd  = first_wr_pending;
                    exp_fwd_data = cmp_e[31:0];
                    first_wr_pending = 1'b0;
                end
            end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            chk("fwd_valid", 64'(fwd_valid), 64'(exp_fwd));
            if (exp_fwd) chk("fwd_data", 64'(fwd_data), 64'(exp_fwd_data));
            if (fwd_valid) begin
                fwd_cnt++;
                fwd_last = fwd_data;
            end
`else
            chk("fwd_tied_zero", 64'({fwd_valid, fwd_data}), 64'd0);
`endif
            chk("done_tag_wr", 64'({done, tag_wr}), 64'({exp_done, exp_done}));
            if (done) begin
                done_cnt++;
                last_tag = tag;
                chk("tag", 64'(tag), 64'(exp_tag));
            end
            if (exp_done) model_busy = 1'b0;
            else if (!model_busy && miss) begin
                model_start(miss_addr);
                model_busy = 1'b1;
            end
        end
    end

    // ---------------- scoreboard for B ----------------
    int b_acc = 0, b_rsp = 0, b_wr_cnt = 0, b_done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_req) chk("b_single_outstanding", 64'(b_acc - b_rsp), 64'd0);
            if (b_req && b_ready) b_acc++;
            if (b_rvalid) b_rsp++;
            if (b_wr_en) begin
                chk("b_wr_word", 64'({b_wr_index, b_wr_offset, b_wr_data}),
                    64'({4'd5, 5'(b_wr_cnt), 32'h1A80 + 32'(b_wr_cnt * 4)}));
                b_wr_cnt++;
            end
            if (b_done) b_done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_miss(input logic [31:0] a);
        @(posedge clk); #1;
        miss_addr = a;
        miss = 1'b1;
        @(posedge clk); #1;
        miss = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(done_cnt), 64'(base + 1));
    endtask

    function automatic logic [31:0] offset_mask();
        logic [31:0] m = '0;
        logic [40:0] w;
        foreach (wr_log[i]) begin
            w = wr_log[i];
            m[w[36:32]] = 1'b1;
        end
        return m;
    endfunction

    // ---------------- directed scenarios ----------------
    int          base, saved_wr, t0, n;
    logic [40:0] w;

    initial begin
        rst_n = 1'b0; miss = 1'b0; miss_addr = '0; b_miss = 1'b0; b_miss_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_outputs_a", 64'({busy, done, mem_req, wr_en, tag_wr, fwd_valid, tag}), 64'd0);
        chk("por_outputs_b", 64'({b_busy, b_done, b_req, b_wr_en, b_tag_wr, b_fwd_valid, b_tag}), 64'd0);
        chk("por_state", 64'(state_a), 64'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic refill: always ready, 3-cycle latency
        base = done_cnt;
        do_miss(32'h0000_1A80);
        wait_done(base, 400, "t1_done_once");
        #1;
        chk("t1_busy_low_after_done", 64'(busy), 64'd0);
        chk("t1_req_count", 64'(req_log.size()), 64'd32);
        chk("t1_first_req", 64'(req_log[0]), 64'h1A80);
        chk("t1_last_req", 64'(req_log[31]), 64'h1AFC);
        chk("t1_write_count", 64'(wr_log.size()), 64'd32);
        w = wr_log[0];
        chk("t1_first_write", 64'(w), 64'({4'd5, 5'd0, 32'h1A80}));
        w = wr_log[31];
        chk("t1_last_write", 64'(w), 64'({4'd5, 5'd31, 32'h1AFC}));
        chk("t1_tag", 64'(last_tag), 64'h3);
        repeat (3) @(posedge clk);
        chk("t1_single_done", 64'(done_cnt), 64'(base + 1));

        // Random backpressure
        rand_ready = 1'b1;
        base = done_cnt;
        do_miss(32'h0004_3200);
        wait_done(base, 800, "t2_done_once");
        rand_ready = 1'b0;
        chk("t2_write_count", 64'(wr_log.size()), 64'd32);
        chk("t2_all_offsets", 64'(offset_mask()), 64'hFFFF_FFFF);
        chk("t2_tag", 64'(last_tag), 64'h86);
        repeat (2) @(posedge clk);

        // Reset after 10 responses, stray response, then a clean refill
        base = done_cnt;
        do_miss(32'h0000_1A80);
        n = 0;
        while (rsp < 10 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("t4_reached_10_rsp", 64'(rsp >= 10), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_async_ctrl_zero", 64'({busy, done, mem_req, wr_en, tag_wr, fwd_valid}), 64'd0);
        chk("t4_async_data_zero", 64'({mem_addr, wr_data}), 64'd0);
        chk("t4_async_state", 64'(state_a), 64'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t4_no_tag_wr", 64'(done_cnt), 64'(base));
        saved_wr = wr_total;
        @(negedge clk);
        stray_tok++;
        repeat (4) @(posedge clk);
        chk("t4_stray_no_write", 64'(wr_total), 64'(saved_wr));
        base = done_cnt;
        do_miss(32'h0000_1A80);
        wait_done(base, 400, "t4_refill_after_reset");
        chk("t4_write_count", 64'(wr_log.size()), 64'd32);

        // Miss during FILL and response in IDLE are ignored
        saved_wr = wr_total;
        @(negedge clk);
        stray_tok++;
        repeat (4) @(posedge clk);
        chk("t5_idle_rvalid_no_write", 64'(wr_total), 64'(saved_wr));
        base = done_cnt;
        do_miss(32'h0000_1A80);
        repeat (5) @(posedge clk);
        do_miss(32'h0000_2000);
        wait_done(base, 400, "t5_done_once");
        chk("t5_req_count", 64'(req_log.size()), 64'd32);
        chk("t5_tag_unchanged", 64'(last_tag), 64'h3);
        repeat (6) @(posedge clk);
        chk("t5_no_second_refill", 64'(done_cnt), 64'(base + 1));
        #1;
        chk("t5_idle_after", 64'(busy), 64'd0);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        // Critical word first with wrap
        base = done_cnt;
        n = fwd_cnt;
        do_miss(32'h0000_1AF8);
        wait_done(base, 400, "t6_done_once");
        chk("t6_req0", 64'(req_log[0]), 64'h1AF8);
        chk("t6_req1", 64'(req_log[1]), 64'h1AFC);
        chk("t6_req2", 64'(req_log[2]), 64'h1A80);
        chk("t6_fwd_once", 64'(fwd_cnt), 64'(n + 1));
        chk("t6_fwd_data", 64'(fwd_last), 64'h1AF8);
        w = wr_log[0];
        chk("t6_first_offset", 64'(w[36:32]), 64'd30);
`endif

        // MAX_OUT=1 instance, 5-cycle latency
        @(posedge clk); #1;
        b_miss_addr = 32'h0000_1A80;
        b_miss = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        b_miss = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        chk("b_done_once", 64'(b_done_cnt), 64'd1);
        chk("b_refill_time_ge_160", 64'((cyc - t0) >= 160), 64'd1);
        chk("b_write_count", 64'(b_wr_cnt), 64'd32);
        chk("b_req_count", 64'(b_acc), 64'd32);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
